// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit -- LIFO stack with a request/response handshake.
//
// Operations (op): 00 PUSH, 01 POP, 10 PEEK, 11 CLEAR. A request is taken when
// req_valid && req_ready. Every accepted request produces exactly one
// resp_valid pulse, carrying data_out and error. A push to a full stack and a
// pop/peek on an empty stack complete with error=1.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only while IDLE)
//   op, data_in       operation code and PUSH operand
//   resp_valid        one-cycle completion pulse
//   data_out, error   response payload, held until the next response
//   empty, full,      occupancy status derived from the registered count
//   count
//   stackPointer      BASE_ADDR - count*(DATA_W/8), modulo 2^32
//
// Build option: STACK_UNIT_TOS_BYPASS_EN adds a top-of-stack register so that
// non-empty POP/PEEK answer one cycle after acceptance instead of two. A POP
// is followed by one extra not-ready cycle while that register is refilled
// from the array.
// -----------------------------------------------------------------------------
module stack_unit #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_03FC,
  parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] data_in,
  output logic              resp_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              error,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic [31:0]       stackPointer
);

  localparam int          IDX_W          = $clog2(DEPTH);
  localparam logic [31:0] BYTES_PER_WORD = 32'(DATA_W / 8);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               error_q, error_d;
  logic               resp_valid_q, resp_valid_d;
  // POP in flight: decrement in READ (default build) or refill after RESP
  // (bypass build).
  logic               pend_pop_q, pend_pop_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  rd_q;
  logic               mem_we_s;
  logic               rd_en_s;
  logic [IDX_W-1:0]   rd_addr_s;
  logic [IDX_W-1:0]   top_idx_s;
  logic               empty_s;
  logic               full_s;
`ifdef STACK_UNIT_TOS_BYPASS_EN
  logic [DATA_W-1:0]  tos_q, tos_d;
`endif

  assign empty_s   = (count_q == {CNT_W{1'b0}});
  assign full_s    = (count_q == CNT_W'(DEPTH));
  // With count == DEPTH the low bits wrap to 0, so minus one still lands on
  // the last entry.
  assign top_idx_s = count_q[IDX_W-1:0] - IDX_W'(1);

  // Next-state, count and response payload.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    error_d      = error_q;
    resp_valid_d = 1'b0;
    pend_pop_d   = pend_pop_q;
    mem_we_s     = 1'b0;
    rd_en_s      = 1'b0;
    rd_addr_s    = top_idx_s;
`ifdef STACK_UNIT_TOS_BYPASS_EN
    tos_d        = tos_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (op)
            OP_PUSH: begin
              state_d      = S_RESP;
              resp_valid_d = 1'b1;
              if (full_s) begin
                error_d = 1'b1;
              end else begin
                mem_we_s = 1'b1;
                count_d  = count_q + CNT_W'(1);
                error_d  = 1'b0;
`ifdef STACK_UNIT_TOS_BYPASS_EN
                tos_d    = data_in;
`endif
              end
            end
            OP_POP, OP_PEEK: begin
              if (empty_s) begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                data_out_d   = {DATA_W{1'b0}};
                error_d      = 1'b1;
                pend_pop_d   = 1'b0;
              end else begin
`ifdef STACK_UNIT_TOS_BYPASS_EN
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                data_out_d   = tos_q;
                error_d      = 1'b0;
                if (op == OP_POP) begin
                  count_d    = count_q - CNT_W'(1);
                  rd_en_s    = 1'b1;
                  rd_addr_s  = top_idx_s - IDX_W'(1);
                  pend_pop_d = 1'b1;
                end else begin
                  pend_pop_d = 1'b0;
                end
`else
                state_d    = S_READ;
                rd_en_s    = 1'b1;
                pend_pop_d = (op == OP_POP);
`endif
              end
            end
            OP_CLEAR: begin
              state_d      = S_RESP;
              resp_valid_d = 1'b1;
              count_d      = {CNT_W{1'b0}};
              data_out_d   = {DATA_W{1'b0}};
              error_d      = 1'b0;
              pend_pop_d   = 1'b0;
`ifdef STACK_UNIT_TOS_BYPASS_EN
              tos_d        = {DATA_W{1'b0}};
`endif
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
`ifdef STACK_UNIT_TOS_BYPASS_EN
        // Refill cycle: the word below the popped entry becomes the new top.
        tos_d      = rd_q;
        pend_pop_d = 1'b0;
        state_d    = S_IDLE;
`else
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        data_out_d   = rd_q;
        error_d      = 1'b0;
        pend_pop_d   = 1'b0;
        if (pend_pop_q) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d = count_q;
        end
`endif
      end
      S_RESP: begin
`ifdef STACK_UNIT_TOS_BYPASS_EN
        if (pend_pop_q) begin
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers; reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= {CNT_W{1'b0}};
      data_out_q   <= {DATA_W{1'b0}};
      error_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      pend_pop_q   <= 1'b0;
`ifdef STACK_UNIT_TOS_BYPASS_EN
      tos_q        <= {DATA_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      error_q      <= error_d;
      resp_valid_q <= resp_valid_d;
      pend_pop_q   <= pend_pop_d;
`ifdef STACK_UNIT_TOS_BYPASS_EN
      tos_q        <= tos_d;
`endif
    end
  end

  // Storage array with registered read; contents are never cleared.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[count_q[IDX_W-1:0]] <= data_in;
    end
    if (rd_en_s && !rst) begin
      rd_q <= mem_q[rd_addr_s];
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = resp_valid_q;
  assign data_out     = data_out_q;
  assign error        = error_q;
  assign empty        = empty_s;
  assign full         = full_s;
  assign count        = count_q;
  assign stackPointer = BASE_ADDR - (32'(count_q) * BYTES_PER_WORD);

endmodule

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// Bench for stack_unit (default build, DATA_W=32, DEPTH=16).
// Expected responses are queued when a request is driven; a monitor pops and
// compares them whenever resp_valid is seen. Scenario tasks also check
// latency and the occupancy/status outputs.
// -----------------------------------------------------------------------------
module tb_stack_unit;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
`ifdef STACK_UNIT_TOS_BYPASS_EN
  localparam int RD_LAT = 1;
`else
  localparam int RD_LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic        resp_valid;
  logic [31:0] data_out;
  logic        error;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic [31:0] stackPointer;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_resp   = 0;

  stack_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .op           (op),
    .data_in      (data_in),
    .resp_valid   (resp_valid),
    .data_out     (data_out),
    .error        (error),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .stackPointer (stackPointer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      n_resp++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 data=%h required no response", data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (error !== e.err || (e.chk_data && data_out !== e.data)) begin
          n_fail++;
          $display("FAIL resp: got data=%h err=%b required data=%h err=%b",
                   data_out, error, e.data, e.err);
        end
      end
    end
  end

  // Drive one request from an IDLE cycle; report cycles until resp_valid (0 = none).
  task automatic issue(input logic [1:0] o, input logic [31:0] d, output int lat);
    req_valid = 1'b1;
    op        = o;
    data_in   = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
`ifdef STACK_UNIT_TOS_BYPASS_EN
    if (!req_ready) begin
      @(posedge clk); #1;
    end
`endif
  endtask

  task automatic expect_resp(input logic [31:0] d, input logic e, input logic chk);
    exp_t x;
    x.data = d; x.err = e; x.chk_data = chk;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; op = OP_PUSH; data_in = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || req_ready !== 1'b1 ||
        resp_valid !== 1'b0 || data_out !== 32'h0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b rdy=%b rv=%b d=%h err=%b required 0 1 0 1 0 0 0",
               count, empty, full, req_ready, resp_valid, data_out, error);
    end
    n_checks++;
    if (stackPointer !== 32'h0000_03FC) begin
      n_fail++;
      $display("FAIL reset_sp: got %h required 000003fc", stackPointer);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_push_basic();
    int lat;
    expect_resp(32'h0, 1'b0, 1'b0);
    issue(OP_PUSH, 32'hA5A5_0001, lat);
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL push_latency: got %0d required 1", lat);
    end
    n_checks++;
    if (count !== 5'd1 || stackPointer !== 32'h0000_03F8 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL push_state: got cnt=%0d sp=%h empty=%b required 1 000003f8 0",
               count, stackPointer, empty);
    end
  endtask

  task automatic test_lifo();
    int lat;
    logic [31:0] v;
    for (int i = 1; i <= 3; i++) begin
      expect_resp(32'h0, 1'b0, 1'b0);
      issue(OP_PUSH, 32'(i), lat);
    end
    n_checks++;
    if (count !== 5'd3) begin
      n_fail++;
      $display("FAIL lifo_fill: got cnt=%0d required 3", count);
    end
    expect_resp(32'd3, 1'b0, 1'b1);
    issue(OP_PEEK, 32'h0, lat);
    n_checks++;
    if (lat !== RD_LAT || count !== 5'd3) begin
      n_fail++;
      $display("FAIL peek: got lat=%0d cnt=%0d required %0d 3", lat, count, RD_LAT);
    end
    for (int i = 3; i >= 1; i--) begin
      v = 32'(i);
      expect_resp(v, 1'b0, 1'b1);
      issue(OP_POP, 32'h0, lat);
      n_checks++;
      if (lat !== RD_LAT || count !== 5'(i - 1)) begin
        n_fail++;
        $display("FAIL pop_%0d: got lat=%0d cnt=%0d required %0d %0d", i, lat, count, RD_LAT, i - 1);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || stackPointer !== 32'h0000_03FC) begin
      n_fail++;
      $display("FAIL lifo_empty: got empty=%b sp=%h required 1 000003fc", empty, stackPointer);
    end
  endtask

  task automatic test_overflow();
    int lat;
    for (int i = 1; i <= 16; i++) begin
      expect_resp(32'h0, 1'b0, 1'b0);
      issue(OP_PUSH, 32'h1000 + 32'(i), lat);
    end
    n_checks++;
    if (count !== 5'd16 || full !== 1'b1 || stackPointer !== 32'h0000_03BC) begin
      n_fail++;
      $display("FAIL fill16: got cnt=%0d full=%b sp=%h required 16 1 000003bc", count, full, stackPointer);
    end
    expect_resp(32'h0, 1'b1, 1'b0);
    issue(OP_PUSH, 32'h0000_DEAD, lat);
    n_checks++;
    if (lat !== 1 || count !== 5'd16 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: got lat=%0d cnt=%0d full=%b required 1 16 1", lat, count, full);
    end
    expect_resp(32'h0000_1010, 1'b0, 1'b1);
    issue(OP_POP, 32'h0, lat);
    n_checks++;
    if (lat !== RD_LAT || count !== 5'd15 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL pop_after_full: got lat=%0d cnt=%0d full=%b required %0d 15 0", lat, count, full, RD_LAT);
    end
    expect_resp(32'h0, 1'b0, 1'b1);
    issue(OP_CLEAR, 32'h0, lat);
  endtask

  task automatic test_underflow();
    int lat;
    expect_resp(32'h0, 1'b1, 1'b1);
    issue(OP_POP, 32'h0, lat);
    n_checks++;
    if (lat !== 1 || count !== 5'd0 || stackPointer !== 32'h0000_03FC) begin
      n_fail++;
      $display("FAIL underflow_pop: got lat=%0d cnt=%0d sp=%h required 1 0 000003fc", lat, count, stackPointer);
    end
    expect_resp(32'h0, 1'b1, 1'b1);
    issue(OP_PEEK, 32'h0, lat);
    n_checks++;
    if (lat !== 1 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL underflow_peek: got lat=%0d cnt=%0d required 1 0", lat, count);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    expect_resp(32'h0, 1'b0, 1'b0);
    issue(OP_PUSH, 32'd7, lat);
    req_valid = 1'b1; op = OP_POP;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    @(negedge clk);
    n_checks++;
    if (count !== 5'd0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: got cnt=%0d rdy=%b required 0 1", count, req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_resp: got %0d responses required 0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    int seen;
    expect_resp(32'h0, 1'b0, 1'b0);
    issue(OP_PUSH, 32'd10, lat);
    expect_resp(32'h0, 1'b0, 1'b0);
    issue(OP_PUSH, 32'd20, lat);
    expect_resp(32'd20, 1'b0, 1'b1);
    seen = 0;
    req_valid = 1'b1; op = OP_POP;
    for (int k = 0; k < RD_LAT + 1; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (seen !== 1 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL held_valid: got %0d responses cnt=%0d required 1 1", seen, count);
    end
    for (int i = 0; i < 5; i++) begin
      expect_resp(32'h0, 1'b0, 1'b0);
      issue(OP_PUSH, 32'h50 + 32'(i), lat);
    end
    n_checks++;
    if (count !== 5'd6 || stackPointer !== 32'h0000_03E4) begin
      n_fail++;
      $display("FAIL pre_clear: got cnt=%0d sp=%h required 6 000003e4", count, stackPointer);
    end
    expect_resp(32'h0, 1'b0, 1'b1);
    issue(OP_CLEAR, 32'h0, lat);
    n_checks++;
    if (lat !== 1 || count !== 5'd0 || stackPointer !== 32'h0000_03FC || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL clear: got lat=%0d cnt=%0d sp=%h empty=%b required 1 0 000003fc 1",
               lat, count, stackPointer, empty);
    end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    expect_resp(32'h0, 1'b0, 1'b1);
    begin
      int lat;
      issue(OP_CLEAR, 32'h0, lat);
    end
    test_lifo();
    test_overflow();
    test_underflow();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expect: got %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
